// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
//   WORD_LEN : instruction word width
//   NOP_WORD : instruction encoding that marks a bubble
package fetch_stage_pkg;
    localparam int WORD_LEN = 16;
    localparam logic [WORD_LEN-1:0] NOP_WORD = 16'h0000;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO holding {pc, instr} pairs.
//   clk, rst   : clock, synchronous active-low reset
//   push, din  : append an entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   clear      : empty the FIFO, wins over push/pop
//   dout       : head entry
//   count      : number of valid entries (0..2)
module fetch_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && (count != 2'd0);
    assign dout    = entry0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b11: begin
                    // Count stays; the new entry lands behind whatever remains.
                    if (count == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end else begin
                        entry0 <= din;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) entry0 <= din;
                    else               entry1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with prefetch buffer and IF/ID register.
//   clk, rst          : clock, synchronous active-low reset
//   hazard_detected   : decode stall, holds a valid IF/ID register
//   br_taken/br_target: redirect pulse and its target address
//   imem_req/addr     : fetch request, held until imem_ack
//   imem_ack/rdata    : fetch response
//   if_valid/instr/pc : IF/ID register towards decode
//
// state   | meaning
// S_FETCH | normal fetching from pc while the buffer has room
// S_DROP  | redirected with a request in flight; wait for its ack and discard it
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter int                  PC_STEP   = 1,
    parameter logic [WORD_LEN-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard_detected,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic                if_valid,
    output logic [WORD_LEN-1:0] if_instr,
    output logic [ADDR_W-1:0]   if_pc
);
    typedef enum logic {S_FETCH, S_DROP} state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          pc;
    logic [ADDR_W-1:0]          drop_addr;
    logic                       armed;
    logic                       req_int;
    logic                       take;
    logic                       load;
    logic                       pop;
    logic [1:0]                 buf_count;
    logic [ADDR_W+WORD_LEN-1:0] buf_head;
    logic [ADDR_W-1:0]          head_pc;
    logic [WORD_LEN-1:0]        head_instr;

    // armed stays low for the first cycle after reset release, so no request
    // is outstanding then and a stray ack from before reset cannot be taken.
    assign req_int   = armed && ((state == S_DROP) || (buf_count != 2'd2));
    assign imem_req  = rst && req_int;
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;

    assign take = imem_ack && req_int && (state == S_FETCH) && !br_taken;
    assign load = !br_taken && (!hazard_detected || !if_valid);
    assign pop  = load && (buf_count != 2'd0);

    assign head_pc    = buf_head[ADDR_W+WORD_LEN-1:WORD_LEN];
    assign head_instr = buf_head[WORD_LEN-1:0];

    fetch_buffer #(.W(ADDR_W + WORD_LEN)) u_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (take),
        .pop   (pop),
        .clear (br_taken),
        .din   ({pc, imem_rdata}),
        .dout  (buf_head),
        .count (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            drop_addr <= '0;
            armed     <= 1'b0;
            if_valid  <= 1'b0;
            if_instr  <= NOP_INSTR;
            if_pc     <= '0;
        end else begin
            armed <= 1'b1;

            if (state == S_FETCH) begin
                if (br_taken) begin
                    pc <= br_target;
                    // An ack in the redirect cycle completes the old request,
                    // so only an unacked one needs draining.
                    if (req_int && !imem_ack) begin
                        state     <= S_DROP;
                        drop_addr <= pc;
                    end
                end else if (take) begin
                    pc <= pc + ADDR_W'(PC_STEP);
                end
            end else begin
                if (br_taken) pc <= br_target;
                if (imem_ack) state <= S_FETCH;
            end

            if (br_taken) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end else if (load) begin
                if (buf_count != 2'd0) begin
                    if_valid <= 1'b1;
                    if_instr <= head_instr;
                    if_pc    <= head_pc;
                end else begin
                    if_valid <= 1'b0;
                    if_instr <= NOP_INSTR;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        hazard_detected;
    logic        br_taken;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model
    int          mem_lat = 0;
    int          mem_cnt = 0;
    bit          mem_rand = 0;
    bit          noise = 0;
    logic [15:0] data_key = 16'h0000;
    bit          last_req, last_ack;
    logic [15:0] last_addr;

    // reference model: pc, pending-drop, buffer queue, decode register
    logic [15:0] m_pc = 0;
    bit          m_drop = 0;
    logic [15:0] m_daddr = 0;
    bit          m_started = 0;
    bit          m_valid = 0;
    logic [15:0] m_instr = 0;
    logic [15:0] m_ifpc = 0;
    logic [31:0] m_q[$];

    function automatic bit m_req();
        return rst && m_started && (m_drop || m_q.size() < 2);
    endfunction

    function automatic logic [15:0] m_addr();
        return m_drop ? m_daddr : m_pc;
    endfunction

    task automatic model_edge(input bit ack);
        bit          req;
        bit          accept;
        logic [31:0] e;
        req = m_req();
        if (!rst) begin
            m_pc = 16'h0000; m_drop = 0; m_daddr = 0; m_started = 0;
            m_valid = 0; m_instr = 16'h0000; m_ifpc = 16'h0000;
            m_q.delete();
            return;
        end
        m_started = 1;
        if (br_taken) begin
            m_q.delete();
            m_valid = 0;
            m_instr = 16'h0000;
            if (m_drop) begin
                if (ack) m_drop = 0;
            end else if (req && !ack) begin
                m_drop  = 1;
                m_daddr = m_pc;
            end
            m_pc = br_target;
        end else begin
            accept = req && ack && !m_drop;
            if (m_drop && ack) m_drop = 0;
            if (!hazard_detected || !m_valid) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    m_valid = 1;
                    m_ifpc  = e[31:16];
                    m_instr = e[15:0];
                end else begin
                    m_valid = 0;
                    m_instr = 16'h0000;
                end
            end
            if (accept) begin
                m_q.push_back({m_pc, 16'(m_pc + data_key)});
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    // one clock: memory answers at negedge, model advances, returns #1 after posedge
    task automatic step();
        @(negedge clk);
        last_req  = imem_req;
        last_addr = imem_addr;
        if (imem_req) begin
            if (mem_cnt >= mem_lat) begin
                imem_ack = 1'b1;
                mem_cnt  = 0;
                if (mem_rand) mem_lat = $urandom_range(0, 3);
            end else begin
                imem_ack = 1'b0;
                mem_cnt++;
            end
        end else begin
            mem_cnt  = 0;
            imem_ack = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        imem_rdata = imem_addr + data_key;
        last_ack   = imem_ack;
        model_edge(imem_ack);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        mem_lat = lat; mem_cnt = 0; mem_rand = 0; noise = 0; data_key = 16'h0000;
        hazard_detected = 0; br_taken = 0; br_target = 0;
        rst = 0;
        step(); step();
        rst = 1;
    endtask

    task automatic run_to_instr(input logic [15:0] v, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid === 1'b1 && if_instr === v) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 0; hazard_detected = 0; br_taken = 0; br_target = 0;
        step(); step(); step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", if_valid); end
        checks++; if (if_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h want=0000", if_instr); end
        checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h want=0000", if_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", imem_req); end
        rst = 1;
    endtask

    task automatic test_stream();
        logic [15:0] got[$];
        logic [15:0] fet[$];
        bit          seen = 0;
        bit          gap = 0;
        do_reset(0);
        for (int i = 0; i < 14; i++) begin
            step();
            if (last_req && last_ack) fet.push_back(last_addr);
            if (if_valid) begin seen = 1; got.push_back(if_instr); end
            else if (seen) gap = 1;
        end
        checks++; if (gap) begin errors++; $display("FAIL stream_gap got=gap want=continuous"); end
        checks++; if (got.size() < 8) begin errors++; $display("FAIL stream_count got=%0d want>=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 16'(i)) begin errors++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, got[i], 16'(i)); end
        end
        for (int i = 0; i < 8 && i < fet.size(); i++) begin
            checks++;
            if (fet[i] !== 16'(i)) begin errors++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, fet[i], 16'(i)); end
        end
    endtask

    task automatic test_hazard();
        bit ok;
        do_reset(0);
        run_to_instr(16'h0003, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hazard_reach3 got=timeout want=instr3"); end
        hazard_detected = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_instr !== 16'h0003) begin
                errors++; $display("FAIL hazard_hold[%0d] got=%b/%h want=1/0003", i, if_valid, if_instr);
            end
        end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hazard_full_req got=%b want=0", imem_req); end
        hazard_detected = 0;
        step();
        checks++; if (if_valid !== 1'b1 || if_instr !== 16'h0004) begin errors++; $display("FAIL hazard_rel0 got=%b/%h want=1/0004", if_valid, if_instr); end
        step();
        checks++; if (if_valid !== 1'b1 || if_instr !== 16'h0005) begin errors++; $display("FAIL hazard_rel1 got=%b/%h want=1/0005", if_valid, if_instr); end
    endtask

    task automatic test_branch();
        bit ok;
        bit found = 0;
        do_reset(0);
        run_to_instr(16'h0003, ok);
        checks++; if (!ok) begin errors++; $display("FAIL branch_reach3 got=timeout want=instr3"); end
        hazard_detected = 1;
        repeat (4) step();
        br_taken = 1; br_target = 16'h0040;
        step();
        br_taken = 0;
        checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000) begin errors++; $display("FAIL branch_flush got=%b/%h want=0/0000", if_valid, if_instr); end
        hazard_detected = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (if_valid) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL branch_timeout got=novalid want=valid"); end
        checks++; if (if_pc !== 16'h0040 || if_instr !== 16'h0040) begin errors++; $display("FAIL branch_target got=%h/%h want=0040/0040", if_pc, if_instr); end
    endtask

    task automatic test_slow_redirect();
        bit found = 0;
        bit held = 1;
        bit acked = 0;
        do_reset(3);
        for (int i = 0; i < 5 && !imem_req; i++) step();
        br_taken = 1; br_target = 16'h0010;
        step();
        br_taken = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_req && imem_addr == 16'h0010) begin found = 1; break; end
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL slow_reach10 got=%h want=0010", imem_addr); end
        step();
        br_taken = 1; br_target = 16'h0100;
        step();
        br_taken = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req !== 1'b1 || imem_addr !== 16'h0010) held = 0;
            step();
            if (last_ack) begin acked = 1; break; end
        end
        checks++; if (!held || !acked) begin errors++; $display("FAIL slow_hold got=held%0d/ack%0d want=1/1", held, acked); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL slow_next got=%b/%h want=1/0100", imem_req, imem_addr); end
        found = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if_valid) begin found = 1; break; end
        end
        checks++; if (!found || if_pc !== 16'h0100) begin errors++; $display("FAIL slow_first got=%b/%h want=1/0100", found, if_pc); end
    endtask

    task automatic test_wrap();
        logic [15:0] fet[$];
        logic [15:0] pcs[$];
        logic [15:0] exp_seq[4];
        exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000; exp_seq[3] = 16'h0001;
        do_reset(0);
        step(); step();
        br_taken = 1; br_target = 16'hFFFE;
        step();
        br_taken = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_req && last_ack) fet.push_back(last_addr);
            if (if_valid) pcs.push_back(if_pc);
        end
        checks++; if (fet.size() < 4 || pcs.size() < 4) begin errors++; $display("FAIL wrap_count got=%0d/%0d want>=4", fet.size(), pcs.size()); end
        for (int i = 0; i < 4 && i < fet.size() && i < pcs.size(); i++) begin
            checks++;
            if (fet[i] !== exp_seq[i] || pcs[i] !== exp_seq[i]) begin
                errors++; $display("FAIL wrap[%0d] got=%h/%h want=%h", i, fet[i], pcs[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found = 0;
        do_reset(0);
        run_to_instr(16'h0003, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_reach3 got=timeout want=instr3"); end
        hazard_detected = 1;
        repeat (3) step();
        rst = 0;
        step();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmid_state got=%b/%b want=0/0", if_valid, imem_req); end
        rst = 1; hazard_detected = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (imem_req) begin found = 1; break; end
        end
        checks++; if (!found || imem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_first got=%b/%h want=1/0000", found, imem_addr); end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset(0);
        mem_rand = 1; noise = 1; data_key = 16'($urandom);
        for (int i = 0; i < 2500; i++) begin
            hazard_detected = ($urandom_range(0, 3) == 0);
            br_taken        = ($urandom_range(0, 19) == 0);
            br_target       = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
            rst             = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (imem_req !== m_req() || (m_req() && imem_addr !== m_addr()) ||
                if_valid !== m_valid || if_instr !== m_instr || (m_valid && if_pc !== m_ifpc)) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random[%0d] got req=%b addr=%h v=%b i=%h pc=%h want req=%b addr=%h v=%b i=%h pc=%h",
                             i, imem_req, imem_addr, if_valid, if_instr, if_pc,
                             m_req(), m_addr(), m_valid, m_instr, m_ifpc);
                end
            end
        end
        rst = 1; hazard_detected = 0; br_taken = 0; noise = 0; mem_rand = 0;
    endtask

    initial begin
        rst = 0; hazard_detected = 0; br_taken = 0; br_target = 0;
        imem_ack = 0; imem_rdata = 0;
        test_reset();
        test_stream();
        test_hazard();
        test_branch();
        test_slow_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
